// File: rtl/adc_pkg.sv
// Shared constants and helpers for the dual-TDC ramp ADC back end.
// Holds default parameters plus the clog2 and code-clamp functions.
package adc_pkg;

  localparam int OFFSET_DEF  = 255;
  localparam int AVG_MAX_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int clamp_code(input int raw, input int maxv);
    if (raw < 0) return 0;
    if (raw > maxv) return maxv;
    return raw;
  endfunction

  function automatic logic clamp_hit(input int raw, input int maxv);
    return (raw < 0) || (raw > maxv);
  endfunction

endpackage

// File: rtl/adc_chan_accum.sv
// One ADC channel: forms the clamped rise/fall code, averages it over
// a power-of-two window and holds one finished result for the arbiter.
module adc_chan_accum
  import adc_pkg::*;
#(
  parameter int FINE_BITS = 9,
  parameter int OFFSET    = OFFSET_DEF,
  parameter int AVG_MAX   = AVG_MAX_DEF,
  parameter int OUT_BITS  = FINE_BITS + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [FINE_BITS-1:0] fine_rise,
  input  logic [FINE_BITS-1:0] fine_fall,
  input  logic                 fine_valid,
  input  logic [2:0]           avg_log2,
  input  logic                 grant,
  output logic                 pend,
  output logic [OUT_BITS-1:0]  result,
  output logic                 clamp_flag,
  output logic                 overflow
);

  localparam int RW   = OUT_BITS + 2;
  localparam int AW   = OUT_BITS + AVG_MAX;
  localparam int CW   = AVG_MAX + 1;
  localparam int MAXV = (1 << OUT_BITS) - 1;
  localparam logic [2:0] NMAX = 3'(AVG_MAX);

  logic signed [RW-1:0] raw;
  logic [OUT_BITS-1:0]  code_d, code_q;
  logic                 code_vld_d, code_vld_q;
  logic [AW-1:0]        acc_d, acc_q, acc_sum;
  logic [CW-1:0]        cnt_d, cnt_q, cnt_inc;
  logic [2:0]           n_d, n_q, n_eff;
  logic                 pend_d, pend_q;
  logic [OUT_BITS-1:0]  res_d, res_q;
  logic                 clamp_d, clamp_q;
  logic                 ovf_d, ovf_q;
  logic                 done;

  always_comb begin
    raw = $signed(RW'(OFFSET))
        - $signed(RW'(fine_fall))
        + $signed(RW'(fine_rise));
    code_vld_d = fine_valid;
    code_d     = code_q;
    clamp_d    = clamp_q;
    if (fine_valid) begin
      code_d  = OUT_BITS'(clamp_code(int'(raw), MAXV));
      clamp_d = clamp_q | clamp_hit(int'(raw), MAXV);
    end
  end

  // Window length is frozen by the first sample of each window.
  always_comb begin
    n_eff   = n_q;
    if (cnt_q == '0)
      n_eff = (avg_log2 > NMAX) ? NMAX : avg_log2;
    acc_sum = acc_q + AW'(code_q);
    cnt_inc = cnt_q + CW'(1);
    done    = code_vld_q && (cnt_inc == (CW'(1) << n_eff));
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    pend_d  = pend_q & ~grant;
    res_d   = res_q;
    ovf_d   = ovf_q;
    if (code_vld_q) begin
      n_d = n_eff;
      if (done) begin
        acc_d = '0;
        cnt_d = '0;
        if (pend_q && !grant) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = 1'b1;
          res_d  = OUT_BITS'(acc_sum >> n_eff);
        end
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      code_q     <= '0;
      code_vld_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      pend_q     <= 1'b0;
      res_q      <= '0;
      clamp_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      code_q     <= code_d;
      code_vld_q <= code_vld_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      pend_q     <= pend_d;
      res_q      <= res_d;
      clamp_q    <= clamp_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pend       = pend_q;
  assign result     = res_q;
  assign clamp_flag = clamp_q;
  assign overflow   = ovf_q;

endmodule

// File: rtl/adc_conv_accum.sv
// Multi-channel ADC back end: per-channel accumulators feeding a
// round-robin arbiter and a valid/ready output register.
module adc_conv_accum
  import adc_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int FINE_BITS = 9,
  parameter int OFFSET    = OFFSET_DEF,
  parameter int AVG_MAX   = AVG_MAX_DEF,
  parameter int OUT_BITS  = FINE_BITS + 1,
  localparam int CHW = (clog2(CHANNELS) > 0) ? clog2(CHANNELS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNELS*FINE_BITS-1:0] fine_rise,
  input  logic [CHANNELS*FINE_BITS-1:0] fine_fall,
  input  logic [CHANNELS-1:0]           fine_valid,
  input  logic [2:0]                    avg_log2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_BITS-1:0]           out_data,
  output logic [CHW-1:0]                out_channel,
  output logic [CHANNELS-1:0]           clamp_flag,
  output logic [CHANNELS-1:0]           overflow
);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] grant;
  logic [OUT_BITS-1:0] result [CHANNELS];

  logic                valid_d, valid_q;
  logic [OUT_BITS-1:0] data_d, data_q;
  logic [CHW-1:0]      ch_d, ch_q;
  logic [CHW-1:0]      ptr_d, ptr_q;
  logic [CHW-1:0]      sel;
  logic                found;
  logic                load;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    adc_chan_accum #(
      .FINE_BITS (FINE_BITS),
      .OFFSET    (OFFSET),
      .AVG_MAX   (AVG_MAX),
      .OUT_BITS  (OUT_BITS)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .fine_rise  (fine_rise[c*FINE_BITS +: FINE_BITS]),
      .fine_fall  (fine_fall[c*FINE_BITS +: FINE_BITS]),
      .fine_valid (fine_valid[c]),
      .avg_log2   (avg_log2),
      .grant      (grant[c]),
      .pend       (pend[c]),
      .result     (result[c]),
      .clamp_flag (clamp_flag[c]),
      .overflow   (overflow[c])
    );
  end

  // ptr_q is the first channel searched, one past the last grant.
  always_comb begin
    load    = !valid_q || out_ready;
    found   = 1'b0;
    sel     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && pend[(int'(ptr_q) + i) % CHANNELS]) begin
        found = 1'b1;
        sel   = CHW'((int'(ptr_q) + i) % CHANNELS);
      end
    end
    grant   = '0;
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        grant[sel] = 1'b1;
        data_d     = result[sel];
        ch_d       = sel;
        ptr_d      = CHW'((int'(sel) + 1) % CHANNELS);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_channel = ch_q;

endmodule

// File: tb/tb_adc_conv_accum.sv
// Bench for adc_conv_accum: directed cases plus random traffic
// scored against a window-averaging reference model.
module tb_adc_conv_accum;

  localparam int CH = 2;
  localparam int FB = 9;
  localparam int OB = 10;

  logic             clk;
  logic             reset;
  logic [CH*FB-1:0] fine_rise;
  logic [CH*FB-1:0] fine_fall;
  logic [CH-1:0]    fine_valid;
  logic [2:0]       avg_log2;
  logic             out_valid;
  logic             out_ready;
  logic [OB-1:0]    out_data;
  logic [0:0]       out_channel;
  logic [CH-1:0]    clamp_flag;
  logic [CH-1:0]    overflow;

  adc_conv_accum dut (
    .clock       (clk),
    .reset       (reset),
    .fine_rise   (fine_rise),
    .fine_fall   (fine_fall),
    .fine_valid  (fine_valid),
    .avg_log2    (avg_log2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_channel (out_channel),
    .clamp_flag  (clamp_flag),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int q0[$];
  int q1[$];
  int m_cnt[CH];
  int m_sum[CH];
  int m_n[CH];
  bit m_clamp[CH];
  bit p_vld[CH];
  int p_code[CH];
  bit sb_on;
  bit alt_on;
  int last_ch;
  int n_acc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int c, input int v);
    if (c == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  // One clock: sample handshake before the edge, then advance the model.
  task automatic tick();
    bit acc;
    bit rst;
    int d;
    int ch;
    int av;
    bit cv[CH];
    int cc[CH];
    bit cl[CH];
    acc = (out_valid === 1'b1) && (out_ready === 1'b1);
    rst = reset;
    d   = int'(out_data);
    ch  = int'(out_channel);
    av  = int'(avg_log2);
    for (int c = 0; c < CH; c++) begin
      int raw;
      raw   = 255 - int'(fine_fall[c*FB +: FB]) + int'(fine_rise[c*FB +: FB]);
      cv[c] = fine_valid[c];
      cl[c] = (raw < 0) || (raw > 1023);
      cc[c] = (raw < 0) ? 0 : ((raw > 1023) ? 1023 : raw);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_cnt[c] = 0; m_sum[c] = 0; m_n[c] = 0;
        m_clamp[c] = 0; p_vld[c] = 0;
      end
      q0.delete();
      q1.delete();
      last_ch = -1;
      return;
    end
    if (acc) begin
      n_acc++;
      if (sb_on) begin
        if (ch == 0) begin
          if (q0.size() == 0) chk("sb_empty_ch0", 1, 0);
          else chk("sb_ch0", d, q0.pop_front());
        end else begin
          if (q1.size() == 0) chk("sb_empty_ch1", 1, 0);
          else chk("sb_ch1", d, q1.pop_front());
        end
      end
      if (alt_on && last_ch >= 0) chk("alternate", ch != last_ch, 1);
      last_ch = ch;
    end
    for (int c = 0; c < CH; c++) begin
      if (p_vld[c]) begin
        if (m_cnt[c] == 0) m_n[c] = (av > 4) ? 4 : av;
        m_sum[c] += p_code[c];
        m_cnt[c]++;
        if (m_cnt[c] == (1 << m_n[c])) begin
          push_exp(c, m_sum[c] >> m_n[c]);
          m_sum[c] = 0;
          m_cnt[c] = 0;
        end
      end
      p_vld[c]  = cv[c];
      p_code[c] = cc[c];
      if (cv[c] && cl[c]) m_clamp[c] = 1;
    end
  endtask

  task automatic drive(input int c, input int r, input int f);
    fine_rise[c*FB +: FB] = 9'(r);
    fine_fall[c*FB +: FB] = 9'(f);
    fine_valid[c] = 1'b1;
  endtask

  task automatic idle(input int n);
    fine_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fine_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int base;
    fine_rise  = '0;
    fine_fall  = '0;
    fine_valid = '0;
    avg_log2   = 3'd0;
    out_ready  = 1'b1;
    sb_on      = 1'b1;
    alt_on     = 1'b0;
    last_ch    = -1;
    n_acc      = 0;
    do_reset();

    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_channel, 0);
    chk("rst_clamp", clamp_flag, 0);
    chk("rst_ovf", overflow, 0);

    // Latency: 100 - 50 + 255 = 305 appears three edges later.
    drive(0, 100, 50);
    tick();
    fine_valid = '0;
    chk("lat_t1", out_valid, 0);
    tick();
    chk("lat_t2", out_valid, 0);
    tick();
    chk("lat_t3", out_valid, 1);
    chk("lat_data", out_data, 305);
    chk("lat_chan", out_channel, 0);
    idle(3);

    drive(0, 0, 300);
    tick();
    fine_valid = '0;
    wait_valid("clamp_valid");
    chk("clamp_data", out_data, 0);
    idle(4);
    chk("clamp_sticky", clamp_flag, 2'b01);

    avg_log2 = 3'd2;
    drive(1, 45, 0); tick();
    drive(1, 46, 0); tick();
    drive(1, 47, 0); tick();
    drive(1, 50, 0); tick();
    fine_valid = '0;
    base = n_acc;
    wait_valid("avg4_valid");
    chk("avg4_data", out_data, 302);
    chk("avg4_chan", out_channel, 1);
    idle(6);
    chk("avg4_count", n_acc - base, 1);
    chk("avg4_drain", q0.size() + q1.size(), 0);

    avg_log2 = 3'd1;
    alt_on   = 1'b1;
    last_ch  = -1;
    base     = n_acc;
    for (int i = 0; i < 8; i++) begin
      drive(0, $urandom_range(0, 511), $urandom_range(0, 511));
      drive(1, $urandom_range(0, 511), $urandom_range(0, 511));
      tick();
    end
    idle(10);
    alt_on = 1'b0;
    chk("rr_count", n_acc - base, 8);
    chk("rr_ovf", overflow, 0);

    // Three back-to-back windows against a stalled output.
    do_reset();
    sb_on     = 1'b0;
    out_ready = 1'b0;
    avg_log2  = 3'd0;
    drive(0, 10, 0); tick();
    drive(0, 20, 0); tick();
    drive(0, 30, 0); tick();
    idle(4);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 265);
    chk("bp_chan", out_channel, 0);
    idle(3);
    chk("bp_hold", out_data, 265);
    chk("bp_hold_v", out_valid, 1);
    chk("bp_ovf", overflow, 2'b01);
    out_ready = 1'b1;
    tick();
    chk("bp_second_v", out_valid, 1);
    chk("bp_second", out_data, 275);
    tick();
    chk("bp_third_dropped", out_valid, 0);

    do_reset();
    sb_on = 1'b1;
    chk("rst2_ovf", overflow, 0);
    chk("rst2_clamp", clamp_flag, 0);
    avg_log2 = 3'd2;
    drive(0, 100, 0); tick();
    drive(0, 100, 0); tick();
    do_reset();
    drive(0, 0, 0);  tick();
    drive(0, 4, 0);  tick();
    drive(0, 8, 0);  tick();
    drive(0, 12, 0); tick();
    fine_valid = '0;
    wait_valid("midrst_valid");
    chk("midrst_data", out_data, 261);
    chk("midrst_chan", out_channel, 0);
    idle(5);

    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) avg_log2 = 3'($urandom_range(1, 7));
      for (int c = 0; c < CH; c++) begin
        fine_rise[c*FB +: FB] = 9'($urandom);
        fine_fall[c*FB +: FB] = 9'($urandom);
        fine_valid[c]         = 1'($urandom);
      end
      tick();
    end
    idle(20);
    chk("rand_drain", q0.size() + q1.size(), 0);
    chk("rand_ovf", overflow, 0);
    chk("rand_clamp", clamp_flag, {m_clamp[1], m_clamp[0]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
